// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for an RV32I core.
// Fetches into the IR, strobes the immediate latch, then steps EXEC / MEM / WB
// one phase per state. A per-phase memory-wait timeout and an illegal-opcode
// check both lead to a terminal TRAP state that only reset can leave.
module multicycle_control_fsm #(
  parameter int INST_WIDTH  = 32,
  parameter int OPCODE      = 7,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  input  logic                  dmem_rvalid_i,
  input  logic                  branch_taken_i,
  output logic [INST_WIDTH-1:0] ir_o,
  output logic [OPCODE-1:0]     opcode_o,
  output logic                  imm_we_o,
  output logic                  alu_we_o,
  output logic                  alu_src_a_o,
  output logic                  alu_src_b_o,
  output logic                  rf_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  pc_we_o,
  output logic [1:0]            pc_sel_o,
  output logic                  retire_o,
  output logic                  trap_o,
  output logic                  illegal_o
);

  // Timeout counter must be able to hold MEM_TIMEOUT itself; keep at least one bit
  // so the design still elaborates when the timeout is disabled.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [OPCODE-1:0] OP_LUI    = OPCODE'(7'b0110111);
  localparam logic [OPCODE-1:0] OP_AUIPC  = OPCODE'(7'b0010111);
  localparam logic [OPCODE-1:0] OP_JAL    = OPCODE'(7'b1101111);
  localparam logic [OPCODE-1:0] OP_JALR   = OPCODE'(7'b1100111);
  localparam logic [OPCODE-1:0] OP_BRANCH = OPCODE'(7'b1100011);
  localparam logic [OPCODE-1:0] OP_LOAD   = OPCODE'(7'b0000011);
  localparam logic [OPCODE-1:0] OP_STORE  = OPCODE'(7'b0100011);
  localparam logic [OPCODE-1:0] OP_ALUI   = OPCODE'(7'b0010011);
  localparam logic [OPCODE-1:0] OP_ALU    = OPCODE'(7'b0110011);

  // IR reset value is ADDI x0,x0,0 (canonical NOP).
  localparam logic [INST_WIDTH-1:0] IR_RESET = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [INST_WIDTH-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    illegal_q, illegal_d;

  logic [OPCODE-1:0] op;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_alui, is_alu, is_legal;
  logic waiting, expire;

  assign op        = ir_q[OPCODE-1:0];
  assign is_lui    = (op == OP_LUI);
  assign is_auipc  = (op == OP_AUIPC);
  assign is_jal    = (op == OP_JAL);
  assign is_jalr   = (op == OP_JALR);
  assign is_branch = (op == OP_BRANCH);
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_alui   = (op == OP_ALUI);
  assign is_alu    = (op == OP_ALU);
  assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                     is_load | is_store | is_alui | is_alu;

  // A wait cycle is a FETCH/MEM cycle whose memory has not answered yet.
  assign waiting = ((state_q == S_FETCH) && !imem_rvalid_i) ||
                   ((state_q == S_MEM)   && !dmem_rvalid_i);

  // Expiry fires on the MEM_TIMEOUT-th consecutive wait cycle; a valid in that
  // same cycle is not a wait cycle, so the normal transition wins.
  assign expire = (MEM_TIMEOUT != 0) && ((int'(cnt_q) + 1) >= MEM_TIMEOUT);

  // State, IR, wait counter and illegal flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_BOOT;
      ir_q      <= IR_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic, IR capture and saturating wait counter.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    cnt_d     = '0;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_rvalid_i) state_d = is_load ? S_WB : S_FETCH;
        else if (expire)   state_d = S_TRAP;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Datapath strobes decoded from the current state and opcode. Branch taken and
  // store completion qualify the PC strobe so the PC advances exactly once.
  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    imm_we_o    = 1'b0;
    alu_we_o    = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'd0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    case (state_q)
      S_FETCH:  imem_req_o = 1'b1;
      S_DECODE: imm_we_o   = 1'b1;
      S_EXEC: begin
        alu_we_o    = 1'b1;
        alu_src_a_o = is_auipc;
        alu_src_b_o = is_alui | is_load | is_store | is_jalr | is_auipc;
        if (is_branch) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        pc_we_o    = is_store & dmem_rvalid_i;
      end
      S_WB: begin
        rf_we_o = 1'b1;
        pc_we_o = 1'b1;
        if (is_load)                wb_sel_o = 2'd1;
        else if (is_jal || is_jalr) wb_sel_o = 2'd2;
        else if (is_lui)            wb_sel_o = 2'd3;
        if (is_jal)                 pc_sel_o = 2'd1;
        else if (is_jalr)           pc_sel_o = 2'd2;
      end
      default: ;
    endcase
  end

  assign retire_o  = pc_we_o;
  assign trap_o    = (state_q == S_TRAP);
  assign illegal_o = illegal_q;
  assign ir_o      = ir_q;
  assign opcode_o  = op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm (MEM_TIMEOUT = 4).
// Each record gives one cycle of inputs and the outputs expected in that cycle.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irv = 1'b0;
  logic [31:0] idata = 32'h0;
  logic        drv = 1'b0;
  logic        bt = 1'b0;

  logic        imem_req, dmem_req, dmem_we, imm_we, alu_we, src_a, src_b;
  logic        rf_we, pc_we, retire, trap, illegal;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] ir;
  logic [6:0]  opcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .INST_WIDTH (32),
    .OPCODE     (7),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_rvalid_i (irv),
    .imem_rdata_i  (idata),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_rvalid_i (drv),
    .branch_taken_i(bt),
    .ir_o          (ir),
    .opcode_o      (opcode),
    .imm_we_o      (imm_we),
    .alu_we_o      (alu_we),
    .alu_src_a_o   (src_a),
    .alu_src_b_o   (src_b),
    .rf_we_o       (rf_we),
    .wb_sel_o      (wb_sel),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .retire_o      (retire),
    .trap_o        (trap),
    .illegal_o     (illegal)
  );

  // Expected-output bit map: {imem_req, dmem_req, dmem_we, imm_we, alu_we, src_a,
  // src_b, rf_we, wb_sel[1:0], pc_we, pc_sel[1:0], retire, trap, illegal}
  localparam logic [15:0] NONE = 16'h0000;
  localparam logic [15:0] IREQ = 16'h8000;
  localparam logic [15:0] DREQ = 16'h4000;
  localparam logic [15:0] DWE  = 16'h2000;
  localparam logic [15:0] IMM  = 16'h1000;
  localparam logic [15:0] ALU  = 16'h0800;
  localparam logic [15:0] SA   = 16'h0400;
  localparam logic [15:0] SB   = 16'h0200;
  localparam logic [15:0] RF   = 16'h0100;
  localparam logic [15:0] PCWE = 16'h0020;
  localparam logic [15:0] RET  = 16'h0004;
  localparam logic [15:0] TRP  = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] BEQ   = 32'h0020_8463;
  localparam logic [31:0] JALR  = 32'h0000_80E7;
  localparam logic [31:0] LUI   = 32'h1234_50B7;
  localparam logic [31:0] AUIPC = 32'h0000_0097;
  localparam logic [31:0] JAL   = 32'h0080_00EF;
  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] BAD   = 32'hFFFF_FFFF;

  function automatic logic [15:0] wb(input int n);
    return 16'(n) << 6;
  endfunction

  function automatic logic [15:0] ps(input int n);
    return 16'(n) << 3;
  endfunction

  typedef struct {
    string       name;
    logic        rst_n;
    logic        irv;
    logic [31:0] idata;
    logic        drv;
    logic        bt;
    logic [15:0] exp;
    logic [31:0] exp_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic iv, input logic [31:0] id,
                     input logic dv, input logic b, input logic [15:0] e, input logic [31:0] eir);
    vec_t v;
    v.name = nm; v.rst_n = r; v.irv = iv; v.idata = id; v.drv = dv; v.bt = b;
    v.exp = e; v.exp_ir = eir;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, then check the outputs.
  task automatic step(input string nm, input logic r, input logic iv, input logic [31:0] id,
                      input logic dv, input logic b, input logic [15:0] e, input logic [31:0] eir);
    logic [15:0] act;
    logic [38:0] want_ir;
    @(negedge clk);
    rst_n = r; irv = iv; idata = id; drv = dv; bt = b;
    #1;
    act = {imem_req, dmem_req, dmem_we, imm_we, alu_we, src_a, src_b, rf_we,
           wb_sel, pc_we, pc_sel, retire, trap, illegal};
    want_ir = {eir, eir[6:0]};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s strobes got %h want %h", nm, act, e);
    end
    checks++;
    if ({ir, opcode} !== want_ir) begin
      errors++;
      $display("FAIL %s ir got %h/%h want %h", nm, ir, opcode, eir);
    end
    $display("cycle %-10s strobes=%h ir=%h", nm, act, ir);
  endtask

  initial begin
    // Reset and release
    add("rst",      0, 0, 0, 0, 0, NONE, NOP);
    add("boot",     1, 0, 0, 0, 0, NONE, NOP);
    // ADDI zero-wait, retire in the 5th cycle after reset release
    add("addi_f",   1, 1, ADDI, 0, 0, IREQ, NOP);
    add("addi_d",   1, 0, 0, 0, 0, IMM, ADDI);
    add("addi_e",   1, 1, 32'hDEADBEEF, 1, 0, ALU | SB, ADDI);
    add("addi_w",   1, 0, 0, 0, 0, RF | PCWE | RET, ADDI);
    // LW with three data-memory waits
    add("lw_f",     1, 1, LW, 0, 0, IREQ, ADDI);
    add("lw_d",     1, 0, 0, 0, 0, IMM, LW);
    add("lw_e",     1, 0, 0, 0, 0, ALU | SB, LW);
    add("lw_m0",    1, 0, 0, 0, 0, DREQ, LW);
    add("lw_m1",    1, 1, ADD, 0, 0, DREQ, LW);
    add("lw_m2",    1, 0, 0, 0, 0, DREQ, LW);
    add("lw_m3",    1, 0, 0, 1, 0, DREQ, LW);
    add("lw_w",     1, 0, 0, 0, 0, RF | wb(1) | PCWE | RET, LW);
    // SW with one wait; retires in MEM on completion
    add("sw_f",     1, 1, SW, 0, 0, IREQ, LW);
    add("sw_d",     1, 0, 0, 0, 0, IMM, SW);
    add("sw_e",     1, 0, 0, 0, 0, ALU | SB, SW);
    add("sw_m0",    1, 0, 0, 0, 0, DREQ | DWE, SW);
    add("sw_m1",    1, 0, 0, 1, 0, DREQ | DWE | PCWE | RET, SW);
    // BEQ taken, then not taken
    add("beq1_f",   1, 1, BEQ, 0, 0, IREQ, SW);
    add("beq1_d",   1, 0, 0, 0, 0, IMM, BEQ);
    add("beq1_e",   1, 0, 0, 0, 1, ALU | PCWE | ps(1) | RET, BEQ);
    add("beq0_f",   1, 1, BEQ, 0, 1, IREQ, BEQ);
    add("beq0_d",   1, 0, 0, 0, 1, IMM, BEQ);
    add("beq0_e",   1, 0, 0, 0, 0, ALU | PCWE | RET, BEQ);
    // JALR
    add("jalr_f",   1, 1, JALR, 0, 0, IREQ, BEQ);
    add("jalr_d",   1, 0, 0, 0, 0, IMM, JALR);
    add("jalr_e",   1, 0, 0, 0, 0, ALU | SB, JALR);
    add("jalr_w",   1, 0, 0, 0, 0, RF | wb(2) | PCWE | ps(2) | RET, JALR);
    // LUI
    add("lui_f",    1, 1, LUI, 0, 0, IREQ, JALR);
    add("lui_d",    1, 0, 0, 0, 0, IMM, LUI);
    add("lui_e",    1, 0, 0, 0, 0, ALU, LUI);
    add("lui_w",    1, 0, 0, 0, 0, RF | wb(3) | PCWE | RET, LUI);
    // AUIPC
    add("auipc_f",  1, 1, AUIPC, 0, 0, IREQ, LUI);
    add("auipc_d",  1, 0, 0, 0, 0, IMM, AUIPC);
    add("auipc_e",  1, 0, 0, 0, 0, ALU | SA | SB, AUIPC);
    add("auipc_w",  1, 0, 0, 0, 0, RF | PCWE | RET, AUIPC);
    // JAL
    add("jal_f",    1, 1, JAL, 0, 0, IREQ, AUIPC);
    add("jal_d",    1, 0, 0, 0, 0, IMM, JAL);
    add("jal_e",    1, 0, 0, 0, 0, ALU, JAL);
    add("jal_w",    1, 0, 0, 0, 0, RF | wb(2) | PCWE | ps(1) | RET, JAL);
    // ADD after two fetch waits
    add("add_f0",   1, 0, 0, 0, 0, IREQ, JAL);
    add("add_f1",   1, 0, 0, 1, 0, IREQ, JAL);
    add("add_f2",   1, 1, ADD, 0, 0, IREQ, JAL);
    add("add_d",    1, 0, 0, 0, 0, IMM, ADD);
    add("add_e",    1, 0, 0, 0, 0, ALU, ADD);
    add("add_w",    1, 0, 0, 0, 0, RF | PCWE | RET, ADD);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst_n, vecs[i].irv, vecs[i].idata, vecs[i].drv,
           vecs[i].bt, vecs[i].exp, vecs[i].exp_ir);
    end

    // Reset asserted mid-MEM drops the data request without waiting for a clock
    step("abort_f",  1, 1, LW, 0, 0, IREQ, ADD);
    step("abort_d",  1, 0, 0, 0, 0, IMM, LW);
    step("abort_e",  1, 0, 0, 0, 0, ALU | SB, LW);
    step("abort_m",  1, 0, 0, 0, 0, DREQ, LW);
    step("abort_rst", 0, 0, 0, 1, 0, NONE, NOP);
    step("abort_boot", 1, 0, 0, 0, 0, NONE, NOP);

    // Fetch valid arrives on the 4th wait cycle: valid wins over expiry
    step("late_f0",  1, 0, 0, 0, 0, IREQ, NOP);
    step("late_f1",  1, 0, 0, 0, 0, IREQ, NOP);
    step("late_f2",  1, 0, 0, 0, 0, IREQ, NOP);
    step("late_f3",  1, 1, ADDI, 0, 0, IREQ, NOP);
    step("late_d",   1, 0, 0, 0, 0, IMM, ADDI);
    step("late_e",   1, 0, 0, 0, 0, ALU | SB, ADDI);
    step("late_w",   1, 0, 0, 0, 0, RF | PCWE | RET, ADDI);

    // Data memory never answers: trap after 4 MEM cycles, not illegal
    step("mto_f",    1, 1, LW, 0, 0, IREQ, ADDI);
    step("mto_d",    1, 0, 0, 0, 0, IMM, LW);
    step("mto_e",    1, 0, 0, 0, 0, ALU | SB, LW);
    for (int k = 0; k < 4; k++) step("mto_m", 1, 0, 0, 0, 0, DREQ, LW);
    step("mto_t0",   1, 0, 0, 1, 0, TRP, LW);
    step("mto_t1",   1, 1, ADD, 1, 0, TRP, LW);
    step("mto_rst",  0, 0, 0, 0, 0, NONE, NOP);
    step("mto_boot", 1, 0, 0, 0, 0, NONE, NOP);

    // Instruction memory never answers: trap after 4 FETCH cycles
    for (int k = 0; k < 4; k++) step("fto_f", 1, 0, 0, 0, 0, IREQ, NOP);
    step("fto_t0",   1, 1, ADDI, 0, 0, TRP, NOP);
    step("fto_t1",   1, 1, ADDI, 0, 0, TRP, NOP);
    step("fto_rst",  0, 0, 0, 0, 0, NONE, NOP);
    step("fto_boot", 1, 0, 0, 0, 0, NONE, NOP);

    // Illegal opcode: DECODE then sticky TRAP with illegal set, IR frozen
    step("ill_f",    1, 1, BAD, 0, 0, IREQ, NOP);
    step("ill_d",    1, 0, 0, 0, 0, IMM, BAD);
    for (int k = 0; k < 3; k++) step("ill_t", 1, 1, ADDI, 1, 1, TRP | ILL, BAD);
    step("ill_rst",  0, 0, 0, 0, 0, NONE, NOP);
    step("ill_boot", 1, 0, 0, 0, 0, NONE, NOP);
    step("ill_f2",   1, 0, 0, 0, 0, IREQ, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
